// File: rtl/l2_bank_rr_scheduler.sv
// Round-robin arbiter sharing one single-port L2 SRAM bank between NB_PORTS TCDM masters,
// with a zero-fill sequencer that runs after reset or on request.
module l2_bank_rr_scheduler #(
   parameter int unsigned NB_PORTS       = 4,
   parameter int unsigned NUM_WORDS      = 8192,
   parameter logic [31:0] BASE_ADDR      = 32'h1C00_0000,
   parameter bit          CLEAR_ON_RESET = 1'b1,
   parameter int unsigned ADDR_W         = $clog2(NUM_WORDS)
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   clr_req_i,
   output logic                   init_done_o,
   input  logic [NB_PORTS-1:0]    req_i,
   input  logic [NB_PORTS*32-1:0] add_i,
   input  logic [NB_PORTS-1:0]    wen_i,
   input  logic [NB_PORTS*32-1:0] wdata_i,
   input  logic [NB_PORTS*4-1:0]  be_i,
   output logic [NB_PORTS-1:0]    gnt_o,
   output logic [NB_PORTS-1:0]    r_valid_o,
   output logic [31:0]            r_rdata_o,
   output logic                   bank_req_o,
   output logic                   bank_we_o,
   output logic [ADDR_W-1:0]      bank_addr_o,
   output logic [31:0]            bank_wdata_o,
   output logic [3:0]             bank_be_o,
   input  logic [31:0]            bank_rdata_i
);

   localparam int unsigned PTR_W = $clog2(NB_PORTS);

   typedef enum logic {S_CLEAR, S_ARB} state_t;

   state_t              r_state, w_state_nxt;
   logic [PTR_W-1:0]    r_rr_ptr, w_ptr_nxt;
   logic [ADDR_W-1:0]   r_clr_cnt, w_clr_nxt;
   logic [NB_PORTS-1:0] r_resp_sel;
   logic [PTR_W-1:0]    w_win;
   logic                w_any;
   logic [31:0]         w_add;

   // Walk the ring backwards so the port closest to rr_ptr is the last (winning) assignment.
   always_comb begin
      w_any = 1'b0;
      w_win = '0;
      for (int k = NB_PORTS-1; k >= 0; k--) begin
         if (req_i[(int'(r_rr_ptr) + k) % NB_PORTS]) begin
            w_any = 1'b1;
            w_win = PTR_W'((int'(r_rr_ptr) + k) % NB_PORTS);
         end
      end
   end

   assign w_add = add_i[int'(w_win)*32 +: 32];

   always_comb begin
      w_state_nxt  = r_state;
      w_ptr_nxt    = r_rr_ptr;
      w_clr_nxt    = r_clr_cnt;
      gnt_o        = '0;
      bank_req_o   = 1'b0;
      bank_we_o    = 1'b0;
      bank_addr_o  = '0;
      bank_wdata_o = '0;
      bank_be_o    = '0;
      case (r_state)
         S_CLEAR: begin
            bank_req_o  = 1'b1;
            bank_we_o   = 1'b1;
            bank_be_o   = 4'hF;
            bank_addr_o = r_clr_cnt;
            w_clr_nxt   = r_clr_cnt + 1'b1;
            if (r_clr_cnt == ADDR_W'(NUM_WORDS-1)) begin
               w_clr_nxt   = '0;
               w_state_nxt = S_ARB;
            end
         end
         S_ARB: begin
            bank_we_o    = ~wen_i[w_win];
            bank_addr_o  = ADDR_W'((w_add - BASE_ADDR) >> 2);
            bank_wdata_o = wdata_i[int'(w_win)*32 +: 32];
            bank_be_o    = be_i[int'(w_win)*4 +: 4];
            if (w_any) begin
               gnt_o[w_win] = 1'b1;
               bank_req_o   = 1'b1;
               w_ptr_nxt    = (w_win == PTR_W'(NB_PORTS-1)) ? '0 : w_win + 1'b1;
            end
            if (clr_req_i) w_state_nxt = S_CLEAR;
         end
         default: w_state_nxt = S_ARB;
      endcase
      // Keep the macro idle and grants low while reset is held, not just from the next edge.
      if (!rst_ni) begin
         gnt_o      = '0;
         bank_req_o = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state    <= CLEAR_ON_RESET ? S_CLEAR : S_ARB;
         r_rr_ptr   <= '0;
         r_clr_cnt  <= '0;
         r_resp_sel <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_rr_ptr   <= w_ptr_nxt;
         r_clr_cnt  <= w_clr_nxt;
         r_resp_sel <= gnt_o;
      end
   end

   assign init_done_o = (r_state == S_ARB);
   assign r_valid_o   = r_resp_sel;
   assign r_rdata_o   = bank_rdata_i;

endmodule

// File: tb/tb_l2_bank_rr_scheduler.sv
// Directed bench for l2_bank_rr_scheduler: SRAM model on the bank side, reference memory
// and response queue on the master side.
module tb_l2_bank_rr_scheduler;

   localparam int          NB   = 4;
   localparam int          NW   = 16;
   localparam int          AW   = 4;
   localparam logic [31:0] BASE = 32'h1C00_0000;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            clr_req;
   logic            init_done;
   logic [NB-1:0]   req;
   logic [NB*32-1:0] add;
   logic [NB-1:0]   wen;
   logic [NB*32-1:0] wdata;
   logic [NB*4-1:0] be;
   logic [NB-1:0]   gnt;
   logic [NB-1:0]   r_valid;
   logic [31:0]     r_rdata;
   logic            bank_req;
   logic            bank_we;
   logic [AW-1:0]   bank_addr;
   logic [31:0]     bank_wdata;
   logic [3:0]      bank_be;
   logic [31:0]     bank_rdata;

   always #5 clk = ~clk;

   l2_bank_rr_scheduler #(
      .NB_PORTS(NB), .NUM_WORDS(NW), .BASE_ADDR(BASE), .CLEAR_ON_RESET(1'b1)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .clr_req_i(clr_req), .init_done_o(init_done),
      .req_i(req), .add_i(add), .wen_i(wen), .wdata_i(wdata), .be_i(be),
      .gnt_o(gnt), .r_valid_o(r_valid), .r_rdata_o(r_rdata),
      .bank_req_o(bank_req), .bank_we_o(bank_we), .bank_addr_o(bank_addr),
      .bank_wdata_o(bank_wdata), .bank_be_o(bank_be), .bank_rdata_i(bank_rdata)
   );

   // 1-cycle-latency single-port SRAM with byte enables
   logic [31:0] sram [NW];
   always @(posedge clk) begin
      if (bank_req) begin
         if (bank_we) begin
            for (int b = 0; b < 4; b++)
               if (bank_be[b]) sram[bank_addr][8*b +: 8] <= bank_wdata[8*b +: 8];
         end else begin
            bank_rdata <= sram[bank_addr];
         end
      end
   end

   typedef struct {
      logic [NB-1:0] vld;
      bit            chk_data;
      logic [31:0]   data;
   } exp_t;

   exp_t        q[$];
   int          checks = 0;
   int          errors = 0;
   int          m_ptr;
   bit          m_clear;
   int          m_cnt;
   logic [31:0] ref_mem [NW];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_port(input int p, input logic [31:0] a, input logic w,
                           input logic [31:0] d, input logic [3:0] b);
      add[p*32 +: 32]   = a;
      wen[p]            = w;
      wdata[p*32 +: 32] = d;
      be[p*4 +: 4]      = b;
   endtask

   function automatic int pick(input logic [NB-1:0] rq, input int ptr);
      for (int k = 0; k < NB; k++)
         if (rq[(ptr + k) % NB]) return (ptr + k) % NB;
      return -1;
   endfunction

   // One clock cycle: called at posedge+1, checks at negedge, returns at next posedge+1.
   task automatic step(input logic [NB-1:0] rq, input logic clr);
      exp_t        e;
      int          w;
      int          a;
      logic [31:0] off;
      logic [31:0] d;
      logic [NB-1:0] g;
      req     = rq;
      clr_req = clr;
      @(negedge clk);
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("r_valid", 32'(r_valid), 32'(e.vld));
         if (e.chk_data) chk("r_rdata", r_rdata, e.data);
      end
      if (m_clear) begin
         chk("clr_gnt", 32'(gnt), 32'h0);
         chk("clr_init_done", 32'(init_done), 32'h0);
         chk("clr_bank_req", 32'(bank_req), 32'h1);
         chk("clr_bank_we", 32'(bank_we), 32'h1);
         chk("clr_bank_addr", 32'(bank_addr), 32'(m_cnt));
         chk("clr_bank_wdata", bank_wdata, 32'h0);
         chk("clr_bank_be", 32'(bank_be), 32'hF);
         q.push_back('{vld: '0, chk_data: 1'b0, data: '0});
         m_cnt++;
         if (m_cnt == NW) begin
            m_cnt   = 0;
            m_clear = 1'b0;
         end
      end else begin
         w = pick(rq, m_ptr);
         chk("init_done", 32'(init_done), 32'h1);
         g = '0;
         if (w >= 0) g[w] = 1'b1;
         chk("gnt", 32'(gnt), 32'(g));
         chk("bank_req", 32'(bank_req), 32'(w >= 0));
         if (w >= 0) begin
            off = add[w*32 +: 32] - BASE;
            a   = int'(off[AW+1:2]);
            chk("bank_addr", 32'(bank_addr), 32'(a));
            chk("bank_we", 32'(bank_we), 32'(!wen[w]));
            if (!wen[w]) begin
               d = wdata[w*32 +: 32];
               chk("bank_wdata", bank_wdata, d);
               chk("bank_be", 32'(bank_be), 32'(be[w*4 +: 4]));
               for (int b = 0; b < 4; b++)
                  if (be[w*4 + b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
               q.push_back('{vld: g, chk_data: 1'b0, data: '0});
            end else begin
               q.push_back('{vld: g, chk_data: 1'b1, data: ref_mem[a]});
            end
            m_ptr = (w + 1) % NB;
         end else begin
            q.push_back('{vld: '0, chk_data: 1'b0, data: '0});
         end
         if (clr) begin
            m_clear = 1'b1;
            m_cnt   = 0;
            for (int i = 0; i < NW; i++) ref_mem[i] = '0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      q.delete();
      m_clear = 1'b1;
      m_cnt   = 0;
      m_ptr   = 0;
      for (int i = 0; i < NW; i++) ref_mem[i] = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; clr_req = 1'b0; req = '0;
      add = '0; wen = '1; wdata = '0; be = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_bank_req", 32'(bank_req), 32'h0);
      chk("rst_r_valid", 32'(r_valid), 32'h0);
      chk("rst_init_done", 32'(init_done), 32'h0);

      // Test 1: power-up clear with all masters already requesting
      for (int p = 0; p < NB; p++)
         set_port(p, BASE + 32'h20 + 32'(4*p), 1'b0, 32'hC0DE_0000 + 32'(p), 4'hF);
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_reset();
      repeat (NW) step(4'hF, 1'b0);

      // Test 2: all requesting -> rotate 0,1,2,3 (writes) then 0,1,2,3,0 (reads)
      repeat (4) step(4'hF, 1'b0);
      wen = '1;
      repeat (5) step(4'hF, 1'b0);

      // Test 3: M2 full-word write then read at word 4
      set_port(2, BASE + 32'h10, 1'b0, 32'hDEAD_BEEF, 4'hF);
      step(4'b0100, 1'b0);
      set_port(2, BASE + 32'h10, 1'b1, 32'h0, 4'hF);
      step(4'b0100, 1'b0);

      // Test 4: single-byte write over a zeroed word
      set_port(0, BASE + 32'h14, 1'b0, 32'h1234_AB56, 4'b0010);
      step(4'b0001, 1'b0);
      set_port(0, BASE + 32'h14, 1'b1, 32'h0, 4'hF);
      step(4'b0001, 1'b0);

      // Out-of-range addresses wrap to the bank word index
      set_port(3, BASE + 32'h48, 1'b0, 32'h5A5A_1234, 4'hF);
      step(4'b1000, 1'b0);
      set_port(1, BASE + 32'h08, 1'b1, 32'h0, 4'hF);
      step(4'b0010, 1'b0);
      set_port(3, BASE - 32'h4, 1'b0, 32'h0BAD_F00D, 4'hF);
      step(4'b1000, 1'b0);
      set_port(3, BASE + 32'h3C, 1'b1, 32'h0, 4'hF);
      step(4'b1000, 1'b0);

      // Mixed request patterns
      for (int p = 0; p < NB; p++)
         set_port(p, BASE + 32'h20 + 32'(4*p), 1'b1, 32'h0, 4'hF);
      step(4'b0101, 1'b0);
      step(4'b0101, 1'b0);
      step(4'b1110, 1'b0);
      step(4'b0000, 1'b0);
      step(4'b1001, 1'b0);

      // Test 5: clear requested alongside an M1 read; M1 keeps requesting through the clear
      set_port(1, BASE + 32'h10, 1'b1, 32'h0, 4'hF);
      step(4'b0010, 1'b1);
      step(4'b0010, 1'b1);
      repeat (NW-1) step(4'b0010, 1'b0);
      step(4'b0010, 1'b0);
      step(4'b0000, 1'b0);

      // Test 6: reset mid-clear, clear restarts from word 0
      step(4'b0000, 1'b1);
      repeat (7) step(4'b0000, 1'b0);
      chk("mid_clear_addr", 32'(bank_addr), 32'h7);
      rst_n = 1'b0;
      #1;
      chk("async_rst_bank_req", 32'(bank_req), 32'h0);
      chk("async_rst_gnt", 32'(gnt), 32'h0);
      chk("async_rst_r_valid", 32'(r_valid), 32'h0);
      chk("async_rst_init_done", 32'(init_done), 32'h0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      req = 4'hF;
      repeat (NW) step(4'hF, 1'b0);
      step(4'hF, 1'b0);
      step(4'h0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
